apb_req_arbiter: RTL and testbench
==================================

// Module: apb_req_arbiter
// PURPOSE
// Shares one APB slave (PSEL1) among N_REQ local requesters. Each requester posts
// a single read/write with a req/done handshake. The block arbitrates round-robin
// and sequences the APB SETUP->ACCESS phases. It returns PRDATA/PSLVERR to the
// winner and aborts transfers the slave never completes (timeout).
// It sits between the bus-master agents and the APB interface signals.
// PARAMETERS
// N_REQ    4   number of requesters (2..16)
// ADDR_W   32  PADDR / req_addr width
// DATA_W   32  PWDATA/PRDATA width
// TIMEOUT  16  max ACCESS cycles waiting for PREADY; 0 = no timeout
// PORTS
// clk         in   1               system clock, all logic on posedge
// PRESET      in   1               synchronous reset, active-high
// req         in   N_REQ           per-requester request, held high until done
// req_write   in   N_REQ           1=write, 0=read, valid while req high
// req_addr    in   N_REQ*ADDR_W    packed addresses, slice i = requester i
// req_wdata   in   N_REQ*DATA_W    packed write data
// done        out  N_REQ           one-cycle completion pulse to the served requester
// rsp_rdata   out  DATA_W          read data, valid while done!=0
// rsp_err     out  1               PSLVERR or timeout, valid while done!=0
// rsp_tmo     out  1               completion was a timeout abort, valid with done
// PSEL1       out  1               APB select
// PENABLE     out  1               APB enable
// PWRITE      out  1               APB direction
// PADDR       out  ADDR_W          APB address
// PWDATA      out  DATA_W          APB write data
// PRDATA      in   DATA_W          APB read data
// PREADY      in   1               APB ready
// PSLVERR     in   1               APB slave error
// BEHAVIOUR
// - All outputs are registered. PRESET drives every output to 0 on the next edge.
//   FSM->IDLE, rr pointer->0, timeout counter->0. Reset mid-transfer drops
//   PSEL1/PENABLE immediately. No done is issued for the aborted transfer.
// - FSM has three states: IDLE, SETUP and ACCESS.
// - IDLE: PSEL1=0, PENABLE=0. If any eligible req, latch the winner index w.
//   Latch req_write[w], req_addr[w] and req_wdata[w] into PWRITE/PADDR/PWDATA.
//   Then -> SETUP, so PSEL1=1 is visible the edge after req is sampled.
// - Eligible = req[i] & ~done[i]. The requester being served this cycle is masked.
// - SETUP: PSEL1=1, PENABLE=0. Always -> ACCESS, so PENABLE=1 exactly one cycle
//   after PSEL1 rises.
// - ACCESS: PSEL1=1, PENABLE=1. PADDR/PWDATA/PWRITE/PSEL1 stay unchanged from
//   SETUP until exit. Count cycles with PREADY=0.
//   - If PREADY=1: capture PRDATA->rsp_rdata and PSLVERR->rsp_err, rsp_tmo=0.
//     Pulse done[w] on the next cycle. PSEL1/PENABLE fall on the next edge.
//     -> IDLE.
//   - Else if TIMEOUT!=0 and the counter reaches TIMEOUT-1: rsp_rdata=0,
//     rsp_err=1, rsp_tmo=1. Pulse done[w] and drop PSEL1/PENABLE on the next edge.
//     -> IDLE.
// - rsp_rdata is 0 for writes.
// - Latency with PREADY tied high: req high at edge 0 -> PSEL1 at edge 1 ->
//   PENABLE at edge 2 -> done at edge 3. Minimum bus gap between transfers is one
//   IDLE cycle (PSEL1=0), and that cycle coincides with done.
// - Round-robin: search starts at rr pointer p and wraps modulo N_REQ.
//   After a grant to w, p <= (w+1) mod N_REQ. After reset, p=0, so index 0 has
//   priority.
// - A requester that drops req before done is still served: the request is
//   latched at grant.
// - req changes after grant have no effect on the current transfer.
// - Simultaneous req from all requesters: served in order p, p+1, ... with no
//   requester served twice before the others.
// TESTING
// - Single read, req[0], addr 0x10, PREADY=1, PRDATA=0xDEADBEEF ->
//   PSEL1@+1, PENABLE@+2, done=4'b0001@+3, rsp_rdata=0xDEADBEEF, rsp_err=0.
// - Write from req[2], PREADY low for 3 ACCESS cycles -> PENABLE held 4 cycles.
//   PADDR/PWDATA stable throughout. done[2] one cycle after PREADY.
// - req=4'b1111 held continuously, each requester releases on its done ->
//   grants in order 0,1,2,3. Each transfer is separated by exactly one PSEL1=0 cycle.
// - PREADY never asserted, TIMEOUT=16 -> PENABLE high 16 cycles, then done with
//   rsp_err=1, rsp_tmo=1, rsp_rdata=0. The next request then proceeds normally.
// - PSLVERR=1 with PREADY -> rsp_err=1, rsp_tmo=0.
// - PRESET during ACCESS -> next edge PSEL1=PENABLE=0 and no done pulse.
//   After reset, req=4'b1010 grants index 1 first.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB slave among N_REQ requesters, sequencing
// SETUP/ACCESS and aborting transfers that wait on PREADY longer than TIMEOUT cycles.
module apb_req_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      PRESET,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          req_write,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata,
   output logic [N_REQ-1:0]          done,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic                      rsp_tmo,
   output logic                      PSEL1,
   output logic                      PENABLE,
   output logic                      PWRITE,
   output logic [ADDR_W-1:0]         PADDR,
   output logic [DATA_W-1:0]         PWDATA,
   input  logic [DATA_W-1:0]         PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR,
   output logic [1:0]                o_dbg_state
);
   // Handshake: a requester holds req until its one-cycle done pulse; the APB side
   // follows SETUP (PSEL1) then ACCESS (PSEL1&PENABLE) until PREADY or timeout.
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETUP = 2'd1, S_ACCESS = 2'd2} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [IDX_W-1:0]  r_ptr;
   logic [IDX_W-1:0]  r_win;
   logic [IDX_W-1:0]  w_win;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_n;
   logic [N_REQ-1:0]  w_elig;
   logic [N_REQ-1:0]  w_done_n;
   logic              w_any;
   logic              w_grant;
   logic              w_tmo_hit;
   logic              w_psel_n;
   logic              w_pen_n;
   logic              w_err_n;
   logic              w_tmo_n;
   logic [DATA_W-1:0] w_rdata_n;

   assign o_dbg_state = r_state;
   assign w_tmo_hit   = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

   // Lowest rotated offset from r_ptr wins; the requester being completed is masked.
   always_comb begin
      int v_idx;
      v_idx  = 0;
      w_elig = req & ~done;
      w_any  = |w_elig;
      w_win  = r_ptr;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         v_idx = int'(r_ptr) + k;
         if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
         if (w_elig[IDX_W'(v_idx)]) w_win = IDX_W'(v_idx);
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_any) w_next = S_SETUP;
         S_SETUP:  w_next = S_ACCESS;
         S_ACCESS: if (PREADY || w_tmo_hit) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_psel_n  = 1'b0;
      w_pen_n   = 1'b0;
      w_grant   = 1'b0;
      w_done_n  = '0;
      w_cnt_n   = '0;
      w_rdata_n = rsp_rdata;
      w_err_n   = rsp_err;
      w_tmo_n   = rsp_tmo;
      case (r_state)
         S_IDLE: begin
            w_grant  = w_any;
            w_psel_n = w_any;
         end
         S_SETUP: begin
            w_psel_n = 1'b1;
            w_pen_n  = 1'b1;
         end
         S_ACCESS: begin
            if (PREADY) begin
               w_done_n[r_win] = 1'b1;
               w_rdata_n       = PWRITE ? '0 : PRDATA;
               w_err_n         = PSLVERR;
               w_tmo_n         = 1'b0;
            end else if (w_tmo_hit) begin
               w_done_n[r_win] = 1'b1;
               w_rdata_n       = '0;
               w_err_n         = 1'b1;
               w_tmo_n         = 1'b1;
            end else begin
               w_psel_n = 1'b1;
               w_pen_n  = 1'b1;
               w_cnt_n  = r_cnt + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (PRESET) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_win     <= '0;
         r_cnt     <= '0;
         PSEL1     <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         done      <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         rsp_tmo   <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_cnt     <= w_cnt_n;
         PSEL1     <= w_psel_n;
         PENABLE   <= w_pen_n;
         done      <= w_done_n;
         rsp_rdata <= w_rdata_n;
         rsp_err   <= w_err_n;
         rsp_tmo   <= w_tmo_n;
         // The request is captured at grant, so later req changes cannot disturb it.
         if (w_grant) begin
            r_win  <= w_win;
            r_ptr  <= (w_win == IDX_W'(N_REQ - 1)) ? '0 : w_win + IDX_W'(1);
            PWRITE <= req_write[w_win];
            PADDR  <= req_addr[int'(w_win) * ADDR_W +: ADDR_W];
            PWDATA <= req_wdata[int'(w_win) * DATA_W +: DATA_W];
         end
      end
   end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed latency/arbitration/timeout/reset cases, then
// randomized requesters and slave, checked by a queue-based scoreboard.
module tb_apb_req_arbiter;
   localparam int N   = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 16;
   localparam int EW  = 4 + DW + 2;

   logic              clk = 1'b0;
   logic              PRESET = 1'b1;
   logic [N-1:0]      req = '0;
   logic [N-1:0]      req_write = '0;
   logic [N*AW-1:0]   req_addr = '0;
   logic [N*DW-1:0]   req_wdata = '0;
   logic [N-1:0]      done;
   logic [DW-1:0]     rsp_rdata;
   logic              rsp_err, rsp_tmo, PSEL1, PENABLE, PWRITE;
   logic [AW-1:0]     PADDR;
   logic [DW-1:0]     PWDATA;
   logic [DW-1:0]     PRDATA = '0;
   logic              PREADY = 1'b0;
   logic              PSLVERR = 1'b0;
   logic [1:0]        dbg_state;

   apb_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .PRESET(PRESET), .req(req), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .done(done),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
      .PSEL1(PSEL1), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .o_dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [EW-1:0] exp_q[$];
   int            g_idx[$];
   int            g_cyc[$];
   logic [AW-1:0] t_addr [N];
   logic [DW-1:0] t_wdata [N];
   bit   [N-1:0]  t_write = '0;
   bit   [N-1:0]  gnt_flag = '0;
   bit   [N-1:0]  busy = '0;
   logic [N-1:0]  elig_snap = '0;
   int            m_ptr = 0;
   int            m_cur = 0;
   int            dir_wait = 0;
   logic [DW-1:0] dir_data = '0;
   bit            dir_err = 1'b0;
   bit            rand_on = 1'b0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: bound expired or impossible event (t=%0t)", nm, $time);
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic post(input int id, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      t_write[id] = wr;
      t_addr[id]  = a;
      t_wdata[id] = d;
      gnt_flag[id] = 1'b0;
      req_write[id] = wr;
      req_addr[id*AW +: AW]  = a;
      req_wdata[id*DW +: DW] = d;
      req[id] = 1'b1;
   endtask

   task automatic do_reset();
      PRESET = 1'b1;
      wait_cycle();
      check("rst_ctrl", {done, rsp_err, rsp_tmo, PSEL1, PENABLE, PWRITE}, 0);
      check("rst_data", {rsp_rdata, PADDR, PWDATA}, 0);
      wait_cycle();
      PRESET = 1'b0;
      m_ptr = 0;
   endtask

   task automatic run_until_done(input int id, input int maxc, output int pen, output bit prev_pen);
      bit ok;
      bit prev;
      ok = 1'b0; prev = 1'b0; pen = 0; prev_pen = 1'b0;
      for (int c = 0; c < maxc; c++) begin
         wait_cycle();
         if (done[id]) begin
            ok = 1'b1;
            prev_pen = prev;
            break;
         end
         if (PENABLE) pen++;
         prev = PENABLE;
      end
      if (!ok) fail_now("wait_done");
      req[id] = 1'b0;
   endtask

   task automatic release_all(input int maxc);
      for (int c = 0; c < maxc; c++) begin
         wait_cycle();
         for (int i = 0; i < N; i++) if (done[i]) req[i] = 1'b0;
         if (req == '0) break;
      end
      if (req != '0) fail_now("release_all");
   endtask

   task automatic requester(input int id);
      int budget;
      busy[id] = 1'b1;
      while (rand_on) begin
         repeat ($urandom_range(0, 5)) @(posedge clk);
         #1;
         if (!rand_on) break;
         post(id, 1'($urandom_range(0, 1)), $urandom, $urandom);
         budget = 0;
         while (!done[id] && budget < 300) begin
            wait_cycle();
            budget++;
            // Occasionally abandon an already-granted request and scribble on its fields.
            if (gnt_flag[id] && req[id] && $urandom_range(0, 7) == 0) begin
               req[id] = 1'b0;
               req_addr[id*AW +: AW]  = $urandom;
               req_wdata[id*DW +: DW] = $urandom;
               req_write[id] = ~req_write[id];
            end
         end
         if (!done[id]) fail_now("req_budget");
         req[id] = 1'b0;
      end
      busy[id] = 1'b0;
   endtask

   // ---------------- reference model + APB slave ----------------
   always @(negedge clk) elig_snap <= req & ~done;

   function automatic int model_winner();
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (m_ptr + k) % N;
         if (elig_snap[idx]) return idx;
      end
      return -1;
   endfunction

   initial begin : slave
      int k, wt, w;
      logic [DW-1:0] dat, e_rd;
      bit er, e_tmo, e_err;
      k = 0; wt = 0;
      forever begin
         wait_cycle();
         if (PRESET) begin
            PREADY = 1'b0;
         end else if (PSEL1 && !PENABLE) begin
            w = model_winner();
            if (w < 0) begin
               fail_now("grant_none");
            end else begin
               g_idx.push_back(w);
               g_cyc.push_back(cyc);
               check("setup_fields", {PWRITE, PADDR, PWDATA}, {t_write[w], t_addr[w], t_wdata[w]});
               m_ptr = (w + 1) % N;
               m_cur = w;
               gnt_flag[w] = 1'b1;
               if (dir_wait >= 0) begin
                  wt = dir_wait; dat = dir_data; er = dir_err;
               end else begin
                  wt = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3);
                  dat = $urandom;
                  er = 1'($urandom_range(0, 3) == 0);
               end
               e_tmo = (wt >= TMO);
               e_rd  = (e_tmo || t_write[w]) ? '0 : dat;
               e_err = e_tmo ? 1'b1 : er;
               exp_q.push_back({4'(w), e_rd, e_err, e_tmo});
            end
            k = 0;
            PREADY = 1'b0;
         end else if (PSEL1 && PENABLE) begin
            check("access_hold", {PWRITE, PADDR, PWDATA}, {t_write[m_cur], t_addr[m_cur], t_wdata[m_cur]});
            if (k == wt) begin
               PREADY = 1'b1; PRDATA = dat; PSLVERR = er;
            end else begin
               PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
            end
            k++;
         end else begin
            PREADY = 1'b0;
         end
      end
   end

   // ---------------- monitor ----------------
   logic [EW-1:0] mon_e;
   logic [N-1:0]  mon_done;
   always @(negedge clk) begin
      if (!PRESET && done != '0) begin
         if (exp_q.size() == 0) begin
            check("done_unexpected", done, 0);
         end else begin
            mon_e = exp_q.pop_front();
            mon_done = N'(1) << mon_e[EW-1 -: 4];
            check("done_vec", done, mon_done);
            check("rsp_rdata", rsp_rdata, mon_e[DW+1:2]);
            check("rsp_err", rsp_err, mon_e[1]);
            check("rsp_tmo", rsp_tmo, mon_e[0]);
            check("done_bus_idle", {PSEL1, PENABLE}, 0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int  pen;
      bit  prev_pen;
      int  no_done;
      for (int i = 0; i < N; i++) begin t_addr[i] = '0; t_wdata[i] = '0; end
      wait_cycle();
      do_reset();

      // single read: latency PSEL1 +1, PENABLE +2, done +3
      dir_wait = 0; dir_data = 32'hDEAD_BEEF; dir_err = 1'b0;
      post(0, 1'b0, 32'h10, 32'h0);
      wait_cycle();
      check("lat_psel", {PSEL1, PENABLE}, 2'b10);
      wait_cycle();
      check("lat_penable", {PSEL1, PENABLE}, 2'b11);
      wait_cycle();
      check("lat_done", done, 4'b0001);
      check("lat_rdata", rsp_rdata, 32'hDEAD_BEEF);
      req[0] = 1'b0;
      repeat (2) wait_cycle();

      // write with three wait states
      dir_wait = 3;
      post(2, 1'b1, 32'h0000_2040, 32'hA5A5_0F0F);
      run_until_done(2, 30, pen, prev_pen);
      check("wr_penable_cycles", pen, 4);
      check("wr_done_after_access", prev_pen, 1);
      repeat (2) wait_cycle();

      // all requesters at once from a fresh pointer
      do_reset();
      dir_wait = 0;
      g_idx.delete(); g_cyc.delete();
      for (int i = 0; i < N; i++) post(i, 1'(i % 2), 32'h100 + 32'(i), 32'h5000 + 32'(i));
      release_all(60);
      check("rr_count", g_idx.size(), 4);
      for (int i = 0; i < g_idx.size(); i++) begin
         check("rr_order", g_idx[i], i);
         if (i > 0) check("rr_spacing", g_cyc[i] - g_cyc[i-1], 3);
      end
      repeat (2) wait_cycle();

      // timeout abort, then a normal transfer
      dir_wait = 1000;
      post(1, 1'b0, 32'h0000_0300, 32'h0);
      run_until_done(1, 40, pen, prev_pen);
      check("tmo_penable_cycles", pen, TMO);
      check("tmo_flags", {rsp_err, rsp_tmo, rsp_rdata}, {2'b11, 32'h0});
      dir_wait = 0; dir_data = 32'h1234_5678;
      post(3, 1'b0, 32'h0000_0400, 32'h0);
      run_until_done(3, 10, pen, prev_pen);
      check("post_tmo_rdata", rsp_rdata, 32'h1234_5678);
      repeat (2) wait_cycle();

      // slave error
      dir_wait = 1; dir_err = 1'b1; dir_data = 32'hCAFE_0001;
      post(0, 1'b0, 32'h0000_0500, 32'h0);
      run_until_done(0, 10, pen, prev_pen);
      check("slverr_flags", {rsp_err, rsp_tmo}, 2'b10);
      dir_err = 1'b0;
      repeat (2) wait_cycle();

      // reset in the middle of ACCESS
      dir_wait = 1000;
      post(2, 1'b1, 32'h0000_0600, 32'h7777_7777);
      for (int c = 0; c < 10 && !PENABLE; c++) wait_cycle();
      if (!PENABLE) fail_now("reach_access");
      repeat (2) wait_cycle();
      PRESET = 1'b1;
      req[2] = 1'b0;
      wait_cycle();
      check("rst_mid_bus", {PSEL1, PENABLE}, 2'b00);
      PRESET = 1'b0;
      m_ptr = 0;
      exp_q.delete();
      no_done = 0;
      for (int c = 0; c < 4; c++) begin
         wait_cycle();
         if (done != '0) no_done++;
      end
      check("rst_no_done", no_done, 0);
      dir_wait = 0;
      g_idx.delete(); g_cyc.delete();
      post(1, 1'b0, 32'h0000_0700, 32'h0);
      post(3, 1'b1, 32'h0000_0704, 32'h9999_0000);
      release_all(30);
      check("rst_first_grant", (g_idx.size() > 0) ? g_idx[0] : -1, 1);
      check("rst_second_grant", (g_idx.size() > 1) ? g_idx[1] : -1, 3);
      repeat (2) wait_cycle();

      // randomized traffic
      dir_wait = -1;
      rand_on = 1'b1;
      for (int i = 0; i < N; i++) begin
         fork
            automatic int id = i;
            requester(id);
         join_none
      end
      repeat (800) wait_cycle();
      rand_on = 1'b0;
      for (int c = 0; c < 600; c++) begin
         wait_cycle();
         if (busy == '0 && !PSEL1) break;
      end
      if (busy != '0) fail_now("drain_busy");
      repeat (3) wait_cycle();
      check("drain_queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
